// File: rtl/debug_module.sv
// debug_module: single-hart RISC-V debug module (0.13 subset) bridging DMI requests to core run-control
module debug_module #(
  parameter int ABITS = 7,
  parameter int DATACOUNT = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             dmi_req_valid,
  output logic             dmi_req_ready,
  input  logic [ABITS-1:0] dmi_req_addr,
  input  logic [31:0]      dmi_req_data,
  input  logic [1:0]       dmi_req_op,
  output logic             dmi_rsp_valid,
  input  logic             dmi_rsp_ready,
  output logic [31:0]      dmi_rsp_data,
  output logic [1:0]       dmi_rsp_op,
  input  logic             hart_halted,
  input  logic             hart_running,
  output logic             haltreq,
  output logic             resumereq,
  output logic             resethaltreq,
  output logic             ndmreset,
  output logic             dmactive
);
  localparam logic [ABITS-1:0] A_DATA0 = ABITS'('h04);
  localparam logic [ABITS-1:0] A_CTL   = ABITS'('h10);
  localparam logic [ABITS-1:0] A_STAT  = ABITS'('h11);
  localparam logic [ABITS-1:0] A_ACS   = ABITS'('h16);
  localparam logic [ABITS-1:0] A_CMD   = ABITS'('h17);
  typedef enum logic {IDLE, RESP} state_t;
  state_t state, state_n;
  logic accept, wr, rd, wr_ctl, active_n, resumeack;
  logic [31:0] data0, rdata, ctl_rd, stat_rd, acs_rd;
  logic [2:0] cmderr;
  // state register for the request/response handshake
  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else state <= state_n;
  // next state and handshake outputs; one transaction in flight at a time
  always_comb begin
    state_n = (state == IDLE) ? (dmi_req_valid ? RESP : IDLE) : (dmi_rsp_ready ? IDLE : RESP);
    dmi_req_ready = (state == IDLE);
    dmi_rsp_valid = (state == RESP);
  end
  // access decode and read mux; a dmcontrol write carries its own dmactive so
  // activation and field writes can land in the same access
  always_comb begin
    accept = dmi_req_valid & dmi_req_ready;
    wr = accept & (dmi_req_op == 2'd2);
    rd = accept & (dmi_req_op == 2'd1);
    wr_ctl = wr & (dmi_req_addr == A_CTL);
    active_n = wr_ctl ? dmi_req_data[0] : dmactive;
    ctl_rd = {haltreq, 29'b0, ndmreset, dmactive};
    stat_rd = {14'b0, resumeack, resumeack, 4'b0, hart_running, hart_running,
               hart_halted, hart_halted, 1'b1, 3'b0, 4'd2};
    acs_rd = {3'b0, 5'd0, 13'b0, cmderr, 4'b0, 4'(DATACOUNT)};
    rdata = (dmi_req_addr == A_DATA0) ? data0 :
            (dmi_req_addr == A_CTL) ? ctl_rd :
            (dmi_req_addr == A_STAT) ? stat_rd :
            (dmi_req_addr == A_ACS) ? acs_rd : 32'h0;
  end
  // response is captured at the accepting edge and held until consumed
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      dmi_rsp_data <= '0;
      dmi_rsp_op <= '0;
    end else if (accept) begin
      dmi_rsp_data <= rd ? rdata : 32'h0;
      dmi_rsp_op <= (dmi_req_op == 2'd3) ? 2'd2 : 2'd0;
    end
  // DM state; everything except dmactive is forced to reset while inactive
  always_ff @(posedge clk or posedge rst)
    if (rst || !active_n) begin
      dmactive <= 1'b0;
      haltreq <= 1'b0;
      ndmreset <= 1'b0;
      resethaltreq <= 1'b0;
      resumereq <= 1'b0;
      resumeack <= 1'b0;
      data0 <= '0;
      cmderr <= '0;
    end else begin
      dmactive <= 1'b1;
      if (wr_ctl) begin
        haltreq <= dmi_req_data[31];
        ndmreset <= dmi_req_data[1];
        resethaltreq <= dmi_req_data[2] ? 1'b0 : (dmi_req_data[3] | resethaltreq);
      end
      if (wr_ctl && dmi_req_data[30] && !dmi_req_data[31]) begin
        resumereq <= 1'b1;
        resumeack <= 1'b0;
      end else if (resumereq && hart_running) begin
        resumereq <= 1'b0;
        resumeack <= 1'b1;
      end
      if (dmactive && wr && dmi_req_addr == A_DATA0) data0 <= dmi_req_data;
      if (dmactive && wr && dmi_req_addr == A_ACS) cmderr <= cmderr & ~dmi_req_data[10:8];
      else if (dmactive && wr && dmi_req_addr == A_CMD && cmderr == 3'd0) cmderr <= 3'd2;
    end
endmodule

// File: tb/tb_debug_module.sv
// tb_debug_module: randomized self-checking bench for debug_module against a register-level model
module tb_debug_module;
  logic clk = 0, rst = 0;
  logic dmi_req_valid = 0, dmi_req_ready, dmi_rsp_valid, dmi_rsp_ready = 1;
  logic [6:0] dmi_req_addr = 0;
  logic [31:0] dmi_req_data = 0, dmi_rsp_data;
  logic [1:0] dmi_req_op = 0, dmi_rsp_op;
  logic hart_halted = 0, hart_running = 0;
  logic haltreq, resumereq, resethaltreq, ndmreset, dmactive;
  int total = 0, bad = 0;
  bit m_active, m_halt, m_ndm, m_rhr, m_pending, m_ack;
  bit [31:0] m_data0;
  int m_cmderr;

  debug_module #(.ABITS(7), .DATACOUNT(1)) dut (
    .clk(clk), .rst(rst),
    .dmi_req_valid(dmi_req_valid), .dmi_req_ready(dmi_req_ready),
    .dmi_req_addr(dmi_req_addr), .dmi_req_data(dmi_req_data), .dmi_req_op(dmi_req_op),
    .dmi_rsp_valid(dmi_rsp_valid), .dmi_rsp_ready(dmi_rsp_ready),
    .dmi_rsp_data(dmi_rsp_data), .dmi_rsp_op(dmi_rsp_op),
    .hart_halted(hart_halted), .hart_running(hart_running),
    .haltreq(haltreq), .resumereq(resumereq), .resethaltreq(resethaltreq),
    .ndmreset(ndmreset), .dmactive(dmactive)
  );

  always #5 clk = ~clk;

  task automatic model_clear();
    m_active = 0; m_halt = 0; m_ndm = 0; m_rhr = 0; m_pending = 0; m_ack = 0;
    m_data0 = 0; m_cmderr = 0;
  endtask

  // one clock edge; a pending resume completes on any edge that sees the hart running
  task automatic tick();
    @(posedge clk);
    if (m_pending && hart_running) begin m_pending = 0; m_ack = 1; end
    #1;
  endtask

  function automatic bit [31:0] model_read(int a);
    case (a)
      'h04: return m_data0;
      'h10: return (m_halt ? 32'h8000_0000 : 0) + (m_ndm ? 2 : 0) + (m_active ? 1 : 0);
      'h11: return (m_ack ? 32'h3_0000 : 0) + (hart_running ? 32'hC00 : 0) +
                   (hart_halted ? 32'h300 : 0) + 32'h80 + 2;
      'h16: return m_cmderr * 256 + 1;
      default: return 0;
    endcase
  endfunction

  task automatic model_write(int a, bit [31:0] d);
    if (a == 'h10) begin
      if (!d[0]) begin model_clear(); return; end
      m_active = 1; m_halt = d[31]; m_ndm = d[1];
      if (d[2]) m_rhr = 0; else if (d[3]) m_rhr = 1;
      if (d[30] && !d[31]) begin m_pending = 1; m_ack = 0; end
    end else if (m_active) begin
      if (a == 'h04) m_data0 = d;
      if (a == 'h16) m_cmderr = m_cmderr & ~int'(d[10:8]);
      if (a == 'h17 && m_cmderr == 0) m_cmderr = 2;
    end
  endtask

  // full transaction with response consumed immediately; returns DUT response and model expectation
  task automatic dmi(input bit [1:0] op, input bit [6:0] a, input bit [31:0] d,
                     output bit [31:0] rdat, output bit [1:0] rop,
                     output bit [31:0] edat, output bit [1:0] eop);
    int n = 0;
    edat = (op == 1) ? model_read(a) : 0;
    eop = (op == 3) ? 2 : 0;
    dmi_req_valid = 1; dmi_req_op = op; dmi_req_addr = a; dmi_req_data = d; dmi_rsp_ready = 1;
    tick();
    if (op == 2) model_write(a, d);
    dmi_req_valid = 0;
    while (!dmi_rsp_valid && n < 10) begin tick(); n++; end
    total++;
    if (!dmi_rsp_valid) begin bad++; $display("FAIL rsp_timeout got=0 exp=1"); end
    rdat = dmi_rsp_data; rop = dmi_rsp_op;
    tick();
  endtask

  task automatic test_reset();
    rst = 1; #2;
    model_clear();
    total++; if (dmi_req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", dmi_req_ready); end
    total++; if (dmi_rsp_valid !== 1'b0) begin bad++; $display("FAIL reset_rsp_valid got=%b exp=0", dmi_rsp_valid); end
    total++; if ({haltreq, resumereq, resethaltreq, ndmreset, dmactive} !== 5'b0) begin
      bad++; $display("FAIL reset_ctrl got=%b exp=00000", {haltreq, resumereq, resethaltreq, ndmreset, dmactive}); end
    total++; if ({dmi_rsp_data, dmi_rsp_op} !== 34'b0) begin bad++; $display("FAIL reset_rsp got=%h exp=0", {dmi_rsp_data, dmi_rsp_op}); end
    tick(); tick();
    rst = 0;
    tick();
  endtask

  task automatic test_halt();
    bit [31:0] r, e; bit [1:0] o, eo;
    dmi(2, 'h10, 32'h8000_0001, r, o, e, eo);
    total++; if ({haltreq, dmactive} !== 2'b11) begin bad++; $display("FAIL halt_out got=%b exp=11", {haltreq, dmactive}); end
    hart_halted = 1;
    dmi(1, 'h11, 0, r, o, e, eo);
    total++; if (r !== 32'h0000_0382 || r !== e) begin bad++; $display("FAIL halt_status got=%h exp=%h", r, 32'h382); end
    total++; if (o !== 2'd0) begin bad++; $display("FAIL halt_status_op got=%0d exp=0", o); end
  endtask

  task automatic test_resume();
    bit [31:0] r, e; bit [1:0] o, eo;
    dmi(2, 'h10, 32'h4000_0001, r, o, e, eo);
    total++; if ({resumereq, haltreq} !== 2'b10) begin bad++; $display("FAIL resume_req got=%b exp=10", {resumereq, haltreq}); end
    repeat (3) tick();
    total++; if (resumereq !== 1'b1) begin bad++; $display("FAIL resume_held got=%b exp=1", resumereq); end
    hart_running = 1; hart_halted = 0;
    tick();
    total++; if (resumereq !== 1'b0 || m_pending) begin bad++; $display("FAIL resume_clear got=%b exp=0", resumereq); end
    dmi(1, 'h11, 0, r, o, e, eo);
    total++; if (r !== 32'h0003_0C82 || r !== e) begin bad++; $display("FAIL resume_status got=%h exp=%h", r, 32'h30C82); end
  endtask

  task automatic test_dmactive();
    bit [31:0] r, e; bit [1:0] o, eo;
    dmi(2, 'h10, 0, r, o, e, eo);
    total++; if (dmactive !== 1'b0) begin bad++; $display("FAIL inactive_out got=%b exp=0", dmactive); end
    dmi(2, 'h04, 32'hDEAD_BEEF, r, o, e, eo);
    dmi(1, 'h04, 0, r, o, e, eo);
    total++; if (r !== 32'h0 || r !== e) begin bad++; $display("FAIL inactive_data0 got=%h exp=0", r); end
    dmi(2, 'h10, 1, r, o, e, eo);
    dmi(2, 'h04, 32'hDEAD_BEEF, r, o, e, eo);
    dmi(1, 'h04, 0, r, o, e, eo);
    total++; if (r !== 32'hDEAD_BEEF || r !== e) begin bad++; $display("FAIL active_data0 got=%h exp=deadbeef", r); end
  endtask

  task automatic test_abstract();
    bit [31:0] r, e; bit [1:0] o, eo;
    dmi(2, 'h17, 32'h1234, r, o, e, eo);
    dmi(1, 'h16, 0, r, o, e, eo);
    total++; if (r !== 32'h0000_0201 || r !== e) begin bad++; $display("FAIL cmderr_set got=%h exp=201", r); end
    dmi(2, 'h16, 32'h0000_0700, r, o, e, eo);
    dmi(1, 'h16, 0, r, o, e, eo);
    total++; if (r !== 32'h0000_0001 || r !== e) begin bad++; $display("FAIL cmderr_clr got=%h exp=1", r); end
  endtask

  task automatic test_backpressure();
    bit [31:0] r, e, d0; bit [1:0] o, eo;
    e = model_read('h11);
    dmi_req_valid = 1; dmi_req_op = 1; dmi_req_addr = 'h11; dmi_rsp_ready = 0;
    tick();
    dmi_req_valid = 0;
    d0 = dmi_rsp_data;
    total++; if (d0 !== e) begin bad++; $display("FAIL bp_data got=%h exp=%h", d0, e); end
    hart_halted = ~hart_halted;
    for (int i = 0; i < 5; i++) begin
      total++;
      if (!dmi_rsp_valid || dmi_req_ready || dmi_rsp_data !== e || dmi_rsp_op !== 2'd0) begin
        bad++; $display("FAIL bp_hold cyc=%0d got=%b%b %h exp=10 %h", i, dmi_rsp_valid, dmi_req_ready, dmi_rsp_data, e); end
      tick();
    end
    dmi_rsp_ready = 1;
    tick();
    total++; if (dmi_rsp_valid !== 1'b0) begin bad++; $display("FAIL bp_release got=%b exp=0", dmi_rsp_valid); end
    dmi(3, 'h04, 32'hFFFF_FFFF, r, o, e, eo);
    total++; if (o !== 2'd2 || r !== 32'h0) begin bad++; $display("FAIL reserved_op got=%0d/%h exp=2/0", o, r); end
    dmi(1, 'h04, 0, r, o, e, eo);
    total++; if (r !== e) begin bad++; $display("FAIL reserved_noeffect got=%h exp=%h", r, e); end
  endtask

  task automatic test_resethalt();
    bit [31:0] r, e; bit [1:0] o, eo;
    dmi(2, 'h10, 32'h0000_000D, r, o, e, eo);
    total++; if (resethaltreq !== 1'b0) begin bad++; $display("FAIL rhr_clrwins got=%b exp=0", resethaltreq); end
    dmi(2, 'h10, 32'h0000_0009, r, o, e, eo);
    total++; if (resethaltreq !== 1'b1) begin bad++; $display("FAIL rhr_set got=%b exp=1", resethaltreq); end
    dmi(2, 'h10, 32'h8000_000B, r, o, e, eo);
    dmi_req_valid = 1; dmi_req_op = 1; dmi_req_addr = 'h11; dmi_rsp_ready = 0;
    tick();
    dmi_req_valid = 0;
    #2 rst = 1; #1;
    total++; if ({dmi_rsp_valid, dmi_rsp_data, dmi_rsp_op, haltreq, resumereq, resethaltreq, ndmreset, dmactive} !== 0) begin
      bad++; $display("FAIL async_rst got=%b %h %b exp=0", dmi_rsp_valid, dmi_rsp_data,
                      {haltreq, resumereq, resethaltreq, ndmreset, dmactive}); end
    total++; if (dmi_req_ready !== 1'b1) begin bad++; $display("FAIL async_rst_ready got=%b exp=1", dmi_req_ready); end
    model_clear();
    #2 rst = 0;
    dmi_rsp_ready = 1;
    tick();
  endtask

  task automatic test_random();
    bit [31:0] r, e, d; bit [1:0] o, eo, op; bit [6:0] a;
    int addrs[6] = '{'h04, 'h10, 'h11, 'h12, 'h16, 'h17};
    dmi(2, 'h10, 1, r, o, e, eo);
    for (int i = 0; i < 300; i++) begin
      hart_running = $urandom_range(0, 1);
      hart_halted = $urandom_range(0, 1);
      a = ($urandom_range(0, 7) == 0) ? 7'($urandom) : 7'(addrs[$urandom_range(0, 5)]);
      op = 2'($urandom);
      d = $urandom;
      if (a == 'h10) d[0] = ($urandom_range(0, 7) != 0);
      dmi(op, a, d, r, o, e, eo);
      total++; if (r !== e || o !== eo) begin bad++; $display("FAIL rand_rsp i=%0d op=%0d a=%h got=%h/%0d exp=%h/%0d", i, op, a, r, o, e, eo); end
      total++;
      if ({haltreq, resumereq, resethaltreq, ndmreset, dmactive} !== {m_halt, m_pending, m_rhr, m_ndm, m_active}) begin
        bad++; $display("FAIL rand_ctrl i=%0d got=%b exp=%b", i, {haltreq, resumereq, resethaltreq, ndmreset, dmactive},
                        {m_halt, m_pending, m_rhr, m_ndm, m_active}); end
    end
  endtask

  initial begin
    test_reset();
    test_halt();
    test_resume();
    test_dmactive();
    test_abstract();
    test_backpressure();
    test_resethalt();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/debug_module.md
# debug_module

RISC-V debug module (single hart, spec 0.13 subset) that consumes DMI transactions from the JTAG debug transport and drives the core's run-control inputs. It replaces the constant `haltreq`/`resumereq`/`resethaltreq` tie-offs at `rv_core` and adds `ndmreset` for SoC reset. Abstract commands are not implemented; the module reports this through `abstractcs.cmderr`.

## Interface
- `ABITS`, 7, DMI address width
- `DATACOUNT`, 1, reported `abstractcs.datacount`; only `data0` is implemented
- `clk` in 1 system clock; all inputs synchronous to it
- `rst` in 1 asynchronous, active-high reset
- `dmi_req_valid` in 1 request valid
- `dmi_req_ready` out 1 request accepted when `valid&ready`
- `dmi_req_addr` in ABITS register address
- `dmi_req_data` in 32 write data
- `dmi_req_op` in 2 0=nop, 1=read, 2=write, 3=reserved
- `dmi_rsp_valid` out 1 response valid
- `dmi_rsp_ready` in 1 response consumed when `valid&ready`
- `dmi_rsp_data` out 32 read data; 0 for nop, write and reserved ops
- `dmi_rsp_op` out 2 0=success, 2=failed
- `hart_halted` in 1 core is in debug/halted state
- `hart_running` in 1 core is executing
- `haltreq` out 1 to core
- `resumereq` out 1 to core
- `resethaltreq` out 1 to core
- `ndmreset` out 1 SoC non-debug reset request
- `dmactive` out 1 `dmcontrol.dmactive`

## Operation
- FSM has two states. IDLE: `dmi_req_ready`=1; on accept, perform the access and go to RESP. RESP: `dmi_rsp_valid`=1; on `dmi_rsp_ready`, go to IDLE.
- Registers:
  - `data0` at 0x04: RW scratch.
  - `dmcontrol` at 0x10: bit31 haltreq (RW), bit30 resumereq (W1), bit3 setresethaltreq (W1), bit2 clrresethaltreq (W1), bit1 ndmreset (RW), bit0 dmactive (RW). Reads return haltreq, ndmreset and dmactive; all other bits read 0.
  - `dmstatus` at 0x11 (RO): bits 17/16 all/anyresumeack, 11/10 all/anyrunning, 9/8 all/anyhalted, bit7 authenticated=1, [3:0]=2.
  - `hartinfo` at 0x12: reads 0.
  - `abstractcs` at 0x16: [28:24]=0, [10:8] cmderr (W1C per bit), [3:0]=DATACOUNT, busy=0.
  - `command` at 0x17 (WO): any write sets cmderr=2 only if cmderr==0.
- Unmapped address: read returns 0, write is ignored, `rsp_op`=0.
- Reserved op (3): no side effect, `rsp_op`=2.
- dmactive=0: every write except to `dmcontrol.dmactive` is ignored. All DM state other than dmactive is held at reset values. `haltreq`, `resumereq`, `resethaltreq` and `ndmreset` are 0.
- `haltreq` output = `dmcontrol.haltreq` (level).
- Writing resumereq=1 with haltreq=0 in the same write:
  - clears resumeack and sets `resume_pending`.
  - `resumereq` output = `resume_pending`.
  - `resume_pending` clears and resumeack sets on the first cycle after the write where `hart_running`=1.
- Writing haltreq=1 and resumereq=1 in the same write: halt wins; resumereq is ignored.
- `resethaltreq` is sticky: set by setresethaltreq, cleared by clrresethaltreq. If both are written in the same write, clear wins.
- `dmstatus` any/all fields are both driven from the single hart's `hart_halted`, `hart_running` and resumeack.

## Timing
- Reset values: all registers and `resume_pending` are 0, FSM is in IDLE. `dmi_req_ready`=1 out of reset. All other outputs are 0.
- Request accepted at edge N. `dmi_rsp_valid`/`data`/`op` are valid from N+1 and held stable until consumed.
- `dmi_req_ready` = 0 while in RESP. There is no overlap: a transaction takes 2 cycles minimum.
- Read data is sampled at the accepting edge. Status inputs that change later do not alter the held response.
- Write side effects take effect at the accepting edge. `haltreq`, `resumereq` and `ndmreset` outputs change at N+1.
- `rst` asserted mid-transaction: response dropped, FSM returns to IDLE, all outputs are reset asynchronously.

## Test plan
- After reset:
  - write `dmcontrol`=0x8000_0001 -> `haltreq`=1, `dmactive`=1.
  - set `hart_halted`=1, read 0x11 -> data 0x0000_0382.
- Halted hart, write `dmcontrol`=0x4000_0001:
  - `resumereq`=1.
  - 3 cycles later raise `hart_running`, drop `hart_halted` -> `resumereq`=0 next cycle.
  - read 0x11 -> 0x0003_0C82.
- dmactive=0, write 0x04=0xDEAD_BEEF, then read 0x04 -> 0.
  - Same sequence with dmactive=1 -> 0xDEAD_BEEF.
- Write 0x17 -> read 0x16 returns 0x0000_0201.
  - Write 0x16=0x0000_0700, read 0x16 -> 0x0000_0001.
- Response backpressure: hold `dmi_rsp_ready`=0 for 5 cycles -> `dmi_rsp_valid`, data and op stay stable, `dmi_req_ready`=0.
  - Reserved op -> `rsp_op`=2.
- Write `dmcontrol`=0x0000_000D -> `resethaltreq`=0 (clear wins).
  - Write 0x0000_0009 -> `resethaltreq`=1.
  - Assert `rst` during RESP -> all outputs 0 immediately.
